// File: rtl/gray_px_streamer.sv
// gray_px_streamer
// ----------------
// Reads one grayscale frame (IMG_W*IMG_H pixels, raster order, one pixel per
// address) from a synchronous single-port memory with one cycle of read
// latency, and streams it to the Sobel datapath with a valid/ready handshake.
// A 2-entry prefetch FIFO hides the read latency, so a consumer that never
// stalls receives one pixel per clock.
//
// Ports
//   sobel_clk      in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   start          in   one-cycle pulse, begins a frame (only honoured in IDLE)
//   mem_rd_en      out  memory read strobe
//   mem_addr       out  pixel index being read
//   mem_rdata      in   read data, valid the cycle after mem_rd_en
//   input_px_gray  out  FIFO head pixel
//   ack_read       out  pixel valid (FIFO not empty)
//   px_ready       in   consumer ready; transfer = ack_read & px_ready
//   busy           out  frame in progress
//   frame_done     out  one-cycle pulse after the last transfer
//
// Build option
//   GRAY_STREAMER_FRAME_LOOP_EN : when defined, DONE restarts the next frame
//   immediately (back-to-back frames, busy held until reset). When undefined,
//   one frame is produced per start.

module gray_px_streamer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int PX_W   = 15,
    parameter int ADDR_W = 17
) (
    input  logic              sobel_clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PX_W-1:0]   mem_rdata,
    output logic [PX_W-1:0]   input_px_gray,
    output logic              ack_read,
    input  logic              px_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int NPX   = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPX - 1);
    localparam logic [CNT_W-1:0]  LAST_XFER = CNT_W'(NPX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic              inflight_q;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PX_W-1:0]   fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;

    logic              xfer;
    logic              wr_en;
    logic              rd_en;
    logic [2:0]        occ_after;

    // FIFO status and handshake
    assign ack_read      = (fifo_cnt_q != 2'd0);
    assign xfer          = ack_read & px_ready;
    assign wr_en         = inflight_q;
    assign input_px_gray = fifo_q[rd_ptr_q];

    // Occupancy the FIFO will have once the in-flight word lands, with the
    // pixel leaving this cycle already subtracted. Counting the departing
    // pixel is what lets a never-stalling consumer see one pixel per clock;
    // xfer implies fifo_cnt_q >= 1, so this never underflows.
    assign occ_after = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, xfer};
    assign rd_en     = (state_q == S_RUN) && (occ_after < 3'd2);

    assign mem_rd_en = rd_en;
    assign mem_addr  = addr_q;

    assign fifo_cnt_d = fifo_cnt_q + {1'b0, wr_en} - {1'b0, xfer};

    // Next-state and FSM outputs
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        xfer_cnt_d = xfer_cnt_q;
        frame_done = 1'b0;
`ifdef GRAY_STREAMER_FRAME_LOOP_EN
        busy       = (state_q != S_IDLE);
`else
        busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
`endif

        if (xfer) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    addr_d     = '0;
                    xfer_cnt_d = '0;
                end
            end
            S_RUN: begin
                // Address saturates at the last pixel; issuing it ends RUN.
                if (rd_en) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last read always lands after RUN is left, so the final
                // transfer can only happen here.
                if (xfer && (xfer_cnt_q == LAST_XFER)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
`ifdef GRAY_STREAMER_FRAME_LOOP_EN
                state_d    = S_RUN;
                addr_d     = '0;
                xfer_cnt_d = '0;
`else
                state_d    = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and counters
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    // Prefetch FIFO; clearing inflight on reset discards a pending read.
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            inflight_q <= rd_en;
            fifo_cnt_q <= fifo_cnt_d;
            if (wr_en) begin
                fifo_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_gray_px_streamer.sv
// Testbench for gray_px_streamer (default build, frame loop disabled).
// Reference model: the consumer must see mem[0], mem[1], ... mem[N-1] in
// order, exactly once each, followed by a frame_done pulse.

module tb_gray_px_streamer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int PX_W   = 15;
    localparam int ADDR_W = 4;
    localparam int N      = IMG_W * IMG_H;

    logic              sobel_clk = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic              px_ready  = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PX_W-1:0]   mem_rdata = '0;
    logic [PX_W-1:0]   input_px_gray;
    logic              ack_read;
    logic              busy;
    logic              frame_done;

    logic [PX_W-1:0]   mem [0:N-1];

    int ncmp = 0;
    int nerr = 0;
    int cyc, nxfer, first_rel, done_rel;
    logic            prev_stall;
    logic [PX_W-1:0] prev_px;

    gray_px_streamer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PX_W  (PX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .sobel_clk    (sobel_clk),
        .reset        (reset),
        .start        (start),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .input_px_gray(input_px_gray),
        .ack_read     (ack_read),
        .px_ready     (px_ready),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 sobel_clk = ~sobel_clk;

    // Synchronous pixel memory, one cycle of read latency.
    always @(posedge sobel_clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle checks, sampled mid-cycle. nxfer = transfers completed in
    // earlier cycles of the current frame.
    task automatic check_cycle(input int mode);
        chk("px_known", 32'($isunknown(input_px_gray)), 32'd0);
        chk("addr_bound", 32'(mem_addr <= ADDR_W'(N - 1)), 32'd1);
        chk("busy", 32'(busy), 32'(cyc >= 1 && nxfer < N));
        chk("frame_done", 32'(frame_done), 32'(nxfer == N && done_rel < 0));
        if (frame_done === 1'b1 && done_rel < 0) done_rel = cyc;
        if (cyc == 1 || cyc == 2) begin
            chk("rd_en_early", 32'(mem_rd_en), 32'd1);
            chk("addr_early", 32'(mem_addr), 32'(cyc - 1));
        end
        if (cyc <= 2) chk("ack_early", 32'(ack_read), 32'd0);
        if (cyc == 3) chk("ack_first", 32'(ack_read), 32'd1);
        if (mode == 2 && cyc >= 3 && cyc < 20) chk("no_read_stalled", 32'(mem_rd_en), 32'd0);
        if (nxfer == N) chk("ack_after_frame", 32'(ack_read), 32'd0);
        if (prev_stall) begin
            chk("hold_ack", 32'(ack_read), 32'd1);
            chk("hold_px", 32'(input_px_gray), 32'(prev_px));
        end
        if (ack_read === 1'b1 && px_ready === 1'b1) begin
            chk("xfer_in_range", 32'(nxfer < N), 32'd1);
            if (nxfer < N) chk("px_data", 32'(input_px_gray), 32'(mem[nxfer]));
            if (first_rel < 0) first_rel = cyc;
            nxfer++;
        end
        prev_stall = (ack_read === 1'b1) && (px_ready === 1'b0);
        prev_px    = input_px_gray;
    endtask

    task automatic tick(input int mode);
        @(negedge sobel_clk);
        check_cycle(mode);
        @(posedge sobel_clk);
        #1;
        cyc++;
    endtask

    // mode 0: ready always; 1: random ready; 2: stalled from cycle 2 to 20.
    // ign_at: cycle of an extra start pulse; stop_at>0 aborts after that many transfers.
    task automatic run_frame(input int mode, input int ign_at, input int stop_at);
        nxfer = 0; first_rel = -1; done_rel = -1; prev_stall = 1'b0; cyc = 0;
        for (int k = 0; k < 400; k++) begin
            if (done_rel >= 0 || (stop_at > 0 && nxfer >= stop_at)) break;
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = (cyc < 2 || cyc >= 20);
            endcase
            start = (cyc == 0 || cyc == ign_at);
            tick(mode);
        end
        start = 1'b0;
        if (stop_at == 0) begin
            chk("done_seen", 32'(done_rel >= 0), 32'd1);
            chk("xfer_count", 32'(nxfer), 32'(N));
            for (int k = 0; k < 3; k++) begin
                px_ready = 1'($urandom_range(0, 1));
                tick(mode);
            end
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = PX_W'($urandom);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = PX_W'(i + 'h100);

        // Reset values
        #12;
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_px", 32'(input_px_gray), 32'd0);
        chk("rst_ack", 32'(ack_read), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        @(posedge sobel_clk); #1; reset = 1'b1;
        @(posedge sobel_clk); #1;

        // Free-flowing frame, 0x100.. pattern
        run_frame(0, -1, 0);
        chk("ff_first", 32'(first_rel), 32'd3);
        chk("ff_done", 32'(done_rel), 32'd15);

        // Start pulse mid-frame is ignored
        run_frame(0, 5, 0);
        chk("ign_first", 32'(first_rel), 32'd3);
        chk("ign_done", 32'(done_rel), 32'd15);

        // Stall at head
        randomize_mem();
        run_frame(2, -1, 0);
        chk("stall_first", 32'(first_rel), 32'd20);

        // Random back-pressure
        for (int f = 0; f < 6; f++) begin
            randomize_mem();
            run_frame(1, -1, 0);
        end

        // Reset mid-frame, then a clean restart
        randomize_mem();
        run_frame(0, -1, 5);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_px", 32'(input_px_gray), 32'd0);
        chk("mid_rst_ack", 32'(ack_read), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge sobel_clk);
        #1 reset = 1'b1;
        @(posedge sobel_clk); #1;
        randomize_mem();
        run_frame(0, -1, 0);
        chk("restart_first", 32'(first_rel), 32'd3);
        chk("restart_done", 32'(done_rel), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
